alarm_tone_sequencer: RTL and testbench
=======================================

Name: alarm_tone_sequencer

Overview:
Controller that sequences the melody ROM and the note-to-tone generator for the RTC alarm. It shares the one speaker path between two requesters: the alarm melody (long, with repeats) and the short key-click beep. It drives the melody ROM address, applies the step timing and the articulation gap, and gives the tone generator a note code plus an enable.

Parameters:
TICK_DIV, 4194304, clk cycles per melody step or beep tick (min 4).
ARTIC, 262144, silent clk cycles at the start of each melody step. Range is 2 <= ARTIC < TICK_DIV.
LAST_ADDR, 227, last melody ROM address played before wrap (8-bit).
REPEATS, 3, number of full melody passes; 0 means endless until stopped (4-bit).
BEEP_NOTE, 22, note code emitted during a beep (8-bit, nonzero).
BEEP_TICKS, 1, beep length in ticks (min 1, 4-bit).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
beep_req  in  1  one-cycle pulse, request key-click beep
alarm_start  in  1  one-cycle pulse, start or restart alarm melody
alarm_stop  in  1  one-cycle pulse, abort alarm melody
rom_addr  out  8  melody ROM address (registered)
rom_note  in  8  melody ROM data; valid one clk after rom_addr changes (synchronous ROM)
note_out  out  8  note code to tone generator (registered); 0 = rest
tone_en  out  1  tone generator enable
alarm_active  out  1  high while in ALARM
beep_active  out  1  high while in BEEP
done  out  1  one-cycle pulse when the alarm completes its REPEATS passes

Behaviour:
- Reset (async, immediate) sets: state IDLE, rom_addr 0, note_out 0, tick_cnt 0, rep_cnt 0, beat_cnt 0, done 0. As a result tone_en, alarm_active and beep_active are all 0.
- States are IDLE, BEEP and ALARM. alarm_active = (state==ALARM). beep_active = (state==BEEP).
- Same-cycle priority: reset > alarm_stop > alarm_start > beep_req.
- Prescaler tick_cnt:
  - Counts 0..TICK_DIV-1 in BEEP and ALARM, then wraps to 0.
  - Cleared on every state entry and on every restart.
  - step_end = (tick_cnt == TICK_DIV-1).
- IDLE:
  - alarm_start → ALARM with rom_addr=0, rep_cnt=0.
  - else beep_req → BEEP with beat_cnt=0.
  - alarm_stop is ignored.
  - note_out=0.
- BEEP:
  - note_out=BEEP_NOTE; tone_en=1 for the whole beep.
  - On step_end: beat_cnt+1; when beat_cnt==BEEP_TICKS-1 → IDLE. Beep length is exactly BEEP_TICKS*TICK_DIV cycles.
  - beep_req restarts the beep (tick_cnt=0, beat_cnt=0).
  - alarm_start abandons the beep and enters ALARM (no done).
  - alarm_stop is ignored.
- ALARM:
  - note_out <= rom_note every cycle. A new address therefore reaches note_out 2 cycles after rom_addr changes; ARTIC >= 2 hides this latency.
  - tone_en = (tick_cnt >= ARTIC) && (note_out != 0).
  - On step_end with rom_addr != LAST_ADDR: rom_addr+1.
  - On step_end with rom_addr == LAST_ADDR:
    - If REPEATS != 0 and rep_cnt == REPEATS-1 → IDLE, done=1 for one cycle, rom_addr=0.
    - Otherwise rep_cnt+1 and rom_addr=0.
  - rep_cnt saturates (never wraps) when REPEATS=0.
  - alarm_start → restart: rom_addr=0, rep_cnt=0, tick_cnt=0.
  - alarm_stop → IDLE next edge, rom_addr=0, no done.
  - beep_req is ignored (dropped, not queued).
- Alarm duration: exactly (LAST_ADDR+1)*REPEATS*TICK_DIV cycles from the alarm_start edge to the done edge.
- done is registered. It is 0 in every other cycle, including stop and preemption exits.
- Rest notes (ROM value 0) keep the step timing but hold tone_en=0.

Test Plan:
(Params for all scenarios: TICK_DIV=8, ARTIC=2, LAST_ADDR=3, REPEATS=2, BEEP_TICKS=2, BEEP_NOTE=22; ROM model returns 20+addr with a 1-clk latency.)
- Basic alarm: pulse alarm_start.
  - rom_addr must run 0,1,2,3,0,1,2,3, each held 8 cycles.
  - note_out must be 20..23 with 2-cycle lag.
  - tone_en must be low at tick_cnt 0-1 and high at 2-7.
  - done must pulse exactly 64 cycles after the start edge, then state IDLE, rom_addr 0.
- Rest note: ROM returns 0 at addr 2 → tone_en must be 0 for all 8 cycles of that step; timing unchanged; done still at 64.
- Beep: pulse beep_req.
  - beep_active=1, note_out=22 and tone_en=1 for exactly 16 cycles, then all 0, no done.
  - Repeat with a second beep_req at cycle 10 → the beep must last 16 cycles from cycle 10.
- Arbitration:
  - beep_req during ALARM → no effect on rom_addr or note_out.
  - alarm_start at beep cycle 5 → ALARM immediately, rom_addr 0, no done.
  - alarm_stop together with alarm_start in IDLE → stays IDLE.
- Endless and stop (REPEATS=0): run more than 5 passes with no done; alarm_stop mid-step → IDLE on the next edge, tone_en 0, rom_addr 0, no done.
- Async reset:
  - Assert reset mid-step between clock edges → all outputs 0 before the next clk edge.
  - Release reset, then pulse alarm_start → sequence restarts from addr 0 with correct timing.

Source files
------------

// File: rtl/alarm_tone_sequencer.sv
// Alarm tone sequencer: shares one speaker path between the alarm melody
// (ROM-driven, stepped, with repeats) and a short key-click beep. It drives
// the melody ROM address and hands the tone generator a note code and enable.
module alarm_tone_sequencer #(
  parameter int unsigned TICK_DIV   = 4194304, // clk cycles per melody step / beep tick
  parameter int unsigned ARTIC      = 262144,  // silent cycles at the start of each melody step
  parameter logic [7:0]  LAST_ADDR  = 8'd227,  // last melody ROM address before wrap
  parameter logic [3:0]  REPEATS    = 4'd3,    // full melody passes, 0 = endless
  parameter logic [7:0]  BEEP_NOTE  = 8'd22,   // note code emitted during a beep
  parameter logic [3:0]  BEEP_TICKS = 4'd1     // beep length in ticks
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beep_req,
  input  logic       alarm_start,
  input  logic       alarm_stop,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_note,
  output logic [7:0] note_out,
  output logic       tone_en,
  output logic       alarm_active,
  output logic       beep_active,
  output logic       done
);

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ARTIC_T   = TW'(ARTIC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEEP  = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [3:0]    beat_cnt, beat_nxt;
  logic [3:0]    rep_cnt, rep_nxt;
  logic [7:0]    addr_nxt;
  logic [7:0]    note_nxt;
  logic          done_nxt;
  logic          step_end;

  assign step_end = (tick_cnt == TICK_LAST);

  // State and datapath registers; reset returns everything to a silent IDLE.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking (<=) so every register samples pre-edge values; blocking here would make results depend on statement order.
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      beat_cnt <= '0;
      rep_cnt  <= '0;
      rom_addr <= '0;
      note_out <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      beat_cnt <= beat_nxt;
      rep_cnt  <= rep_nxt;
      rom_addr <= addr_nxt;
      note_out <= note_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state, step timing, address sequencing and note selection.
  always_comb begin
    // NOTE: every variable gets a default first so no branch leaves one unassigned, which would infer a latch.
    state_nxt = state;
    tick_nxt  = tick_cnt;
    beat_nxt  = beat_cnt;
    rep_nxt   = rep_cnt;
    addr_nxt  = rom_addr;
    done_nxt  = 1'b0;
    note_nxt  = 8'd0;

    case (state)
      S_IDLE: begin
        tick_nxt = '0;
        // alarm_stop has no work to do here but still outranks the other
        // requests that arrive in the same cycle.
        if (!alarm_stop) begin
          if (alarm_start) begin
            state_nxt = S_ALARM;
            addr_nxt  = 8'd0;
            rep_nxt   = 4'd0;
          end else if (beep_req) begin
            state_nxt = S_BEEP;
            beat_nxt  = 4'd0;
          end
        end
      end

      S_BEEP: begin
        if (!alarm_stop && alarm_start) begin
          // Alarm preempts the beep outright; no done for the abandoned beep.
          state_nxt = S_ALARM;
          tick_nxt  = '0;
          addr_nxt  = 8'd0;
          rep_nxt   = 4'd0;
        end else if (!alarm_stop && beep_req) begin
          // A new key press restarts the click from the beginning.
          tick_nxt = '0;
          beat_nxt = 4'd0;
        end else if (step_end) begin
          tick_nxt = '0;
          if (beat_cnt == BEEP_TICKS - 4'd1) begin
            state_nxt = S_IDLE;
            beat_nxt  = 4'd0;
          end else begin
            beat_nxt = beat_cnt + 4'd1;
          end
        end else begin
          tick_nxt = tick_cnt + 1'b1;
        end
      end

      S_ALARM: begin
        if (alarm_stop) begin
          state_nxt = S_IDLE;
          tick_nxt  = '0;
          addr_nxt  = 8'd0;
        end else if (alarm_start) begin
          tick_nxt = '0;
          addr_nxt = 8'd0;
          rep_nxt  = 4'd0;
        end else if (step_end) begin
          tick_nxt = '0;
          if (rom_addr == LAST_ADDR) begin
            addr_nxt = 8'd0;
            if ((REPEATS != 4'd0) && (rep_cnt == REPEATS - 4'd1)) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end else begin
              // Saturate so an endless alarm never wraps the pass counter.
              rep_nxt = (rep_cnt == 4'hF) ? rep_cnt : rep_cnt + 4'd1;
            end
          end else begin
            addr_nxt = rom_addr + 8'd1;
          end
        end else begin
          tick_nxt = tick_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        tick_nxt  = '0;
        addr_nxt  = 8'd0;
      end
    endcase

    // Note follows the state being entered so a beep sounds from its first
    // cycle and the note is silenced on the same edge that leaves ALARM.
    case (state_nxt)
      S_BEEP:  note_nxt = BEEP_NOTE;
      S_ALARM: note_nxt = rom_note;
      default: note_nxt = 8'd0;
    endcase
  end

  assign alarm_active = (state == S_ALARM);
  assign beep_active  = (state == S_BEEP);

  // The articulation gap hides the two-cycle ROM-to-note latency after each
  // address change; rest notes (code 0) keep timing but stay silent.
  assign tone_en = (state == S_BEEP) ||
                   ((state == S_ALARM) && (tick_cnt >= ARTIC_T) && (note_out != 8'd0));

endmodule

// File: tb/tb_alarm_tone_sequencer.sv
// Scoreboard bench for alarm_tone_sequencer. Two instances share the inputs:
// one with REPEATS=2 (finite alarm) and one with REPEATS=0 (endless alarm).
module tb_alarm_tone_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic beep_req = 1'b0;
  logic alarm_start = 1'b0;
  logic alarm_stop = 1'b0;
  logic rest_en = 1'b0;

  logic [7:0] rom_addr_a, note_out_a;
  logic [7:0] rom_note_a = 8'd0;
  logic       tone_en_a, alarm_active_a, beep_active_a, done_a;
  logic [7:0] rom_addr_e, note_out_e;
  logic [7:0] rom_note_e = 8'd0;
  logic       tone_en_e, alarm_active_e, beep_active_e, done_e;

  always #5 clk = ~clk;

  alarm_tone_sequencer #(
    .TICK_DIV(8), .ARTIC(2), .LAST_ADDR(8'd3), .REPEATS(4'd2),
    .BEEP_NOTE(8'd22), .BEEP_TICKS(4'd2)
  ) dut (
    .clk(clk), .reset(reset), .beep_req(beep_req), .alarm_start(alarm_start),
    .alarm_stop(alarm_stop), .rom_addr(rom_addr_a), .rom_note(rom_note_a),
    .note_out(note_out_a), .tone_en(tone_en_a), .alarm_active(alarm_active_a),
    .beep_active(beep_active_a), .done(done_a)
  );

  alarm_tone_sequencer #(
    .TICK_DIV(8), .ARTIC(2), .LAST_ADDR(8'd3), .REPEATS(4'd0),
    .BEEP_NOTE(8'd22), .BEEP_TICKS(4'd2)
  ) dut_e (
    .clk(clk), .reset(reset), .beep_req(beep_req), .alarm_start(alarm_start),
    .alarm_stop(alarm_stop), .rom_addr(rom_addr_e), .rom_note(rom_note_e),
    .note_out(note_out_e), .tone_en(tone_en_e), .alarm_active(alarm_active_e),
    .beep_active(beep_active_e), .done(done_e)
  );

  // Synchronous melody ROMs: 20+addr, optional rest at address 2.
  always @(posedge clk) rom_note_a <= (rest_en && rom_addr_a == 8'd2) ? 8'd0 : 8'd20 + rom_addr_a;
  always @(posedge clk) rom_note_e <= 8'd20 + rom_addr_e;

  typedef struct {
    bit         sel;      // 0 = finite instance, 1 = endless instance
    logic [7:0] addr;
    logic [7:0] note;
    bit         chk_note;
    bit         tone;
    bit         aa;
    bit         ba;
    bit         dn;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(bit sel, logic [7:0] addr, logic [7:0] note, bit cn,
                              bit tone, bit aa, bit ba, bit dn, string tag);
    exp_t e;
    e.sel = sel; e.addr = addr; e.note = note; e.chk_note = cn;
    e.tone = tone; e.aa = aa; e.ba = ba; e.dn = dn; e.tag = tag;
    return e;
  endfunction

  function automatic exp_t idle_exp(bit sel, bit dn, string tag);
    return mk(sel, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, dn, tag);
  endfunction

  function automatic exp_t beep_exp(string tag);
    return mk(1'b0, 8'd0, 8'd22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, tag);
  endfunction

  // Expected outputs a cycles after the alarm_start edge: 8-cycle steps over
  // addresses 0..3, tone gated off for the first two cycles of each step.
  function automatic exp_t alarm_exp(bit sel, int a, bit rest, string tag);
    int k = a / 8;
    int t = a % 8;
    logic [7:0] addr = 8'(k % 4);
    logic [7:0] note = (rest && addr == 8'd2) ? 8'd0 : 8'd20 + addr;
    return mk(sel, addr, note, t >= 2, (t >= 2) && (note != 8'd0), 1'b1, 1'b0, 1'b0, tag);
  endfunction

  // Apply request pulses to the next edge and queue the outputs expected after it.
  task automatic tick(input bit b, input bit s, input bit p, input exp_t e);
    beep_req = b; alarm_start = s; alarm_stop = p;
    @(posedge clk);
    #1;
    beep_req = 1'b0; alarm_start = 1'b0; alarm_stop = 1'b0;
    sb.push_back(e);
  endtask

  task automatic run_alarm(input bit rest, input int beep_at, input string tag);
    for (int a = 0; a < 64; a++)
      tick(a == beep_at, a == 0, 1'b0, alarm_exp(1'b0, a, rest, tag));
    tick(1'b0, 1'b0, 1'b0, idle_exp(1'b0, 1'b1, {tag, "_done"}));
    tick(1'b0, 1'b0, 1'b0, idle_exp(1'b0, 1'b0, {tag, "_post"}));
  endtask

  // Monitor: one queued expectation is compared per cycle, mid-cycle.
  exp_t       me;
  logic [7:0] m_addr, m_note;
  logic       m_tone, m_aa, m_ba, m_dn;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      if (me.sel) begin
        m_addr = rom_addr_e; m_note = note_out_e; m_tone = tone_en_e;
        m_aa = alarm_active_e; m_ba = beep_active_e; m_dn = done_e;
      end else begin
        m_addr = rom_addr_a; m_note = note_out_a; m_tone = tone_en_a;
        m_aa = alarm_active_a; m_ba = beep_active_a; m_dn = done_a;
      end
      check({me.tag, ".rom_addr"}, m_addr, me.addr);
      if (me.chk_note) check({me.tag, ".note_out"}, m_note, me.note);
      check({me.tag, ".tone_en"}, {7'd0, m_tone}, {7'd0, me.tone});
      check({me.tag, ".alarm_active"}, {7'd0, m_aa}, {7'd0, me.aa});
      check({me.tag, ".beep_active"}, {7'd0, m_ba}, {7'd0, me.ba});
      check({me.tag, ".done"}, {7'd0, m_dn}, {7'd0, me.dn});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1 sb.push_back(idle_exp(1'b0, 1'b0, "reset_a"));
    @(posedge clk);
    #1 sb.push_back(idle_exp(1'b1, 1'b0, "reset_e"));
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0, idle_exp(1'b0, 1'b0, "idle"));

    // Basic alarm, rest note, and beep requests ignored during ALARM.
    run_alarm(1'b0, -1, "basic");
    rest_en = 1'b1;
    run_alarm(1'b1, -1, "rest");
    rest_en = 1'b0;
    run_alarm(1'b0, 12, "beep_in_alarm");

    // Single beep: 16 cycles of BEEP, then silent IDLE without done.
    tick(1'b1, 1'b0, 1'b0, beep_exp("beep"));
    for (int c = 1; c < 16; c++) tick(1'b0, 1'b0, 1'b0, beep_exp("beep"));
    tick(1'b0, 1'b0, 1'b0, idle_exp(1'b0, 1'b0, "beep_end"));
    tick(1'b0, 1'b0, 1'b0, idle_exp(1'b0, 1'b0, "beep_post"));

    // Beep restarted at cycle 10 lasts 16 cycles from the restart.
    tick(1'b1, 1'b0, 1'b0, beep_exp("beep2"));
    for (int c = 1; c < 10; c++) tick(1'b0, 1'b0, 1'b0, beep_exp("beep2"));
    tick(1'b1, 1'b0, 1'b0, beep_exp("beep2_restart"));
    for (int c = 1; c < 16; c++) tick(1'b0, 1'b0, 1'b0, beep_exp("beep2_restart"));
    tick(1'b0, 1'b0, 1'b0, idle_exp(1'b0, 1'b0, "beep2_end"));

    // alarm_start at beep cycle 5 preempts the beep; full alarm follows.
    tick(1'b1, 1'b0, 1'b0, beep_exp("preempt_beep"));
    for (int c = 1; c < 5; c++) tick(1'b0, 1'b0, 1'b0, beep_exp("preempt_beep"));
    run_alarm(1'b0, -1, "preempt");

    // alarm_stop together with alarm_start in IDLE: stays IDLE.
    tick(1'b0, 1'b1, 1'b1, idle_exp(1'b0, 1'b0, "stop_start"));
    tick(1'b0, 1'b0, 1'b0, idle_exp(1'b0, 1'b0, "stop_start_post"));

    // Endless alarm: six passes plus part of a step, then stop at tick 4.
    for (int a = 0; a < 196; a++)
      tick(1'b0, a == 0, 1'b0, alarm_exp(1'b1, a, 1'b0, "endless"));
    tick(1'b0, 1'b0, 1'b1, idle_exp(1'b1, 1'b0, "endless_stop"));
    tick(1'b0, 1'b0, 1'b0, idle_exp(1'b1, 1'b0, "endless_post"));

    // Asynchronous reset between edges, mid-step.
    for (int a = 0; a < 20; a++)
      tick(1'b0, a == 0, 1'b0, alarm_exp(1'b0, a, 1'b0, "pre_reset"));
    @(posedge clk);
    #2 reset = 1'b1;
    sb.push_back(idle_exp(1'b0, 1'b0, "async_reset_a"));
    @(posedge clk);
    #1 sb.push_back(idle_exp(1'b1, 1'b0, "async_reset_e"));
    @(posedge clk);
    #3 reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0, idle_exp(1'b0, 1'b0, "post_reset_idle"));
    run_alarm(1'b0, -1, "after_reset");

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
